// File: rtl/cell_stream_rx_checker.sv
// Cell-link RX packet checker: delineates header/payload/checksum packets,
// forwards payload words and reports per-packet verdicts with saturating counters.
module cell_stream_rx_checker #(
  parameter logic [15:0] MAGIC     = 16'hA5C3,
  parameter int          MAX_WORDS = 32,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        auroraUserClk,
  input  logic        auroraResetN,
  input  logic [31:0] rx_tdata,
  input  logic        rx_tlast,
  input  logic        rx_tvalid,
  output logic [31:0] pay_tdata,
  output logic        pay_tvalid,
  output logic [7:0]  pay_index,
  output logic        pkt_good,
  output logic        pkt_bad,
  output logic [2:0]  err_code,
  output logic [7:0]  src_id,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

  state_t        r_state, w_nextState;
  logic [7:0]    r_len, r_idx, r_srcLatch;
  logic [31:0]   r_sum;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_payData;
  logic [7:0]    r_payIndex, r_srcId;
  logic          r_payValid, r_good, r_bad;
  logic [2:0]    r_err;
  logic [15:0]   r_goodCount, r_badCount;

  logic          w_magicOk, w_lenOk, w_lastPayload, w_timeout;
  logic          w_fwd, w_good, w_bad;
  logic [2:0]    w_err;
  logic [15:0]   w_goodCountNext, w_badCountNext;

  assign w_magicOk     = (rx_tdata[31:16] == MAGIC);
  assign w_lenOk       = (rx_tdata[7:0] != 8'd0) && (int'(rx_tdata[7:0]) <= MAX_WORDS);
  assign w_lastPayload = ((r_idx + 8'd1) == r_len);
  // The TIMEOUT-th consecutive idle cycle mid-packet is the aborting cycle.
  assign w_timeout     = (r_state != S_IDLE) && !rx_tvalid && (r_timer == TLIM);

  always_ff @(posedge auroraUserClk) begin
    if (!auroraResetN) r_state <= S_IDLE;
    else               r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_tvalid && !rx_tlast)
          w_nextState = (w_magicOk && w_lenOk) ? S_PAYLOAD : S_DRAIN;
      end
      S_PAYLOAD: begin
        if (rx_tvalid) begin
          if (rx_tlast)           w_nextState = S_IDLE;
          else if (w_lastPayload) w_nextState = S_CHECK;
        end else if (w_timeout) begin
          w_nextState = S_IDLE;
        end
      end
      S_CHECK: begin
        if (rx_tvalid)      w_nextState = rx_tlast ? S_IDLE : S_DRAIN;
        else if (w_timeout) w_nextState = S_IDLE;
      end
      S_DRAIN: begin
        if ((rx_tvalid && rx_tlast) || w_timeout) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_fwd  = 1'b0;
    w_good = 1'b0;
    w_bad  = 1'b0;
    w_err  = 3'd0;
    case (r_state)
      S_IDLE: begin
        if (rx_tvalid) begin
          if (rx_tlast)        begin w_bad = 1'b1; w_err = 3'd3; end
          else if (!w_magicOk) begin w_bad = 1'b1; w_err = 3'd1; end
          else if (!w_lenOk)   begin w_bad = 1'b1; w_err = 3'd2; end
        end
      end
      S_PAYLOAD: begin
        if (rx_tvalid) begin
          if (rx_tlast) begin w_bad = 1'b1; w_err = 3'd3; end
          else          w_fwd = 1'b1;
        end else if (w_timeout) begin
          w_bad = 1'b1; w_err = 3'd6;
        end
      end
      S_CHECK: begin
        if (rx_tvalid) begin
          if (!rx_tlast)              begin w_bad = 1'b1; w_err = 3'd4; end
          else if (rx_tdata != r_sum) begin w_bad = 1'b1; w_err = 3'd5; end
          else                        w_good = 1'b1;
        end else if (w_timeout) begin
          w_bad = 1'b1; w_err = 3'd6;
        end
      end
      default: ;
    endcase
  end

  assign w_goodCountNext = (w_good && r_goodCount != 16'hFFFF) ? r_goodCount + 16'd1 : r_goodCount;
  assign w_badCountNext  = (w_bad  && r_badCount  != 16'hFFFF) ? r_badCount  + 16'd1 : r_badCount;

  always_ff @(posedge auroraUserClk) begin
    if (!auroraResetN) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_srcLatch  <= '0;
      r_sum       <= '0;
      r_timer     <= '0;
      r_payData   <= '0;
      r_payIndex  <= '0;
      r_payValid  <= 1'b0;
      r_good      <= 1'b0;
      r_bad       <= 1'b0;
      r_err       <= '0;
      r_srcId     <= '0;
      r_goodCount <= '0;
      r_badCount  <= '0;
    end else begin
      if (r_state == S_IDLE || rx_tvalid || w_timeout) r_timer <= '0;
      else                                           r_timer <= r_timer + TW'(1);
      if (r_state == S_IDLE && rx_tvalid) begin
        r_len      <= rx_tdata[7:0];
        r_srcLatch <= rx_tdata[15:8];
        r_sum      <= rx_tdata;
        r_idx      <= '0;
      end else if (w_fwd) begin
        r_sum <= r_sum + rx_tdata;
        r_idx <= r_idx + 8'd1;
      end
      r_payValid <= w_fwd;
      if (w_fwd) begin
        r_payData  <= rx_tdata;
        r_payIndex <= r_idx;
      end
      r_good <= w_good;
      r_bad  <= w_bad;
      if (w_bad)  r_err   <= w_err;
      if (w_good) r_srcId <= r_srcLatch;
      r_goodCount <= w_goodCountNext;
      r_badCount  <= w_badCountNext;
    end
  end

  assign pay_tdata  = r_payData;
  assign pay_tvalid = r_payValid;
  assign pay_index  = r_payIndex;
  assign pkt_good   = r_good;
  assign pkt_bad    = r_bad;
  assign err_code   = r_err;
  assign src_id     = r_srcId;
  assign good_count = r_goodCount;
  assign bad_count  = r_badCount;

endmodule

// File: tb/tb_cell_stream_rx_checker.sv
// Bench for cell_stream_rx_checker: directed packets from the test plan plus
// random packet mixes, checked against a packet-level reference model.
module tb_cell_stream_rx_checker;

  localparam logic [15:0] MAGIC     = 16'hA5C3;
  localparam int          MAX_WORDS = 32;
  localparam int          TIMEOUT   = 1024;

  logic        auroraUserClk = 1'b0;
  logic        auroraResetN  = 1'b0;
  logic [31:0] rx_tdata      = '0;
  logic        rx_tlast      = 1'b0;
  logic        rx_tvalid     = 1'b0;
  logic [31:0] pay_tdata;
  logic        pay_tvalid;
  logic [7:0]  pay_index;
  logic        pkt_good, pkt_bad;
  logic [2:0]  err_code;
  logic [7:0]  src_id;
  logic [15:0] good_count, bad_count;

  cell_stream_rx_checker #(.MAGIC(MAGIC), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .auroraUserClk(auroraUserClk), .auroraResetN(auroraResetN),
    .rx_tdata(rx_tdata), .rx_tlast(rx_tlast), .rx_tvalid(rx_tvalid),
    .pay_tdata(pay_tdata), .pay_tvalid(pay_tvalid), .pay_index(pay_index),
    .pkt_good(pkt_good), .pkt_bad(pkt_bad), .err_code(err_code), .src_id(src_id),
    .good_count(good_count), .bad_count(bad_count)
  );

  always #5 auroraUserClk = ~auroraUserClk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          gap;
  } beat_t;

  beat_t       beats[$];
  logic [39:0] expPay[$];
  logic [39:0] gotPay[$];
  int          gotGood = 0, gotBad = 0, gotBoth = 0;
  int          expGood = 0, expBad = 0;
  logic [15:0] expGoodCnt = '0, expBadCnt = '0;
  logic [2:0]  expErr = '0;
  logic [7:0]  expSrc = '0;
  int          payChecked = 0;
  int          vectors = 0, miscompares = 0;

  // Output observer, sampled mid-cycle so it never races the stimulus.
  always begin
    @(posedge auroraUserClk);
    #2;
    if (pay_tvalid) gotPay.push_back({pay_index, pay_tdata});
    if (pkt_good) gotGood++;
    if (pkt_bad) gotBad++;
    if (pkt_good && pkt_bad) gotBoth++;
  end

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic addBeat(input logic [31:0] data, input logic last, input int gap);
    beat_t b;
    b.data = data;
    b.last = last;
    b.gap  = gap;
    beats.push_back(b);
  endtask

  task automatic applyStimulus();
    foreach (beats[i]) begin
      rx_tvalid = 1'b0;
      rx_tlast  = 1'b0;
      repeat (beats[i].gap) @(negedge auroraUserClk);
      rx_tdata  = beats[i].data;
      rx_tlast  = beats[i].last;
      rx_tvalid = 1'b1;
      @(negedge auroraUserClk);
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    beats.delete();
  endtask

  task automatic expectBad(input logic [2:0] code);
    expBad++;
    if (expBadCnt != 16'hFFFF) expBadCnt++;
    expErr = code;
  endtask

  task automatic expectGood(input logic [7:0] src);
    expGood++;
    if (expGoodCnt != 16'hFFFF) expGoodCnt++;
    expSrc = src;
  endtask

  // Packet-level verdict for one complete packet starting at beats[start].
  task automatic predict(input int start);
    logic [31:0] hdr, sum;
    int n;
    hdr = beats[start].data;
    n   = int'(hdr[7:0]);
    if (beats[start].last)           expectBad(3'd3);
    else if (hdr[31:16] != MAGIC)    expectBad(3'd1);
    else if (n == 0 || n > MAX_WORDS) expectBad(3'd2);
    else begin
      sum = hdr;
      for (int k = 1; k <= n; k++) begin
        if (beats[start + k].last) begin
          expectBad(3'd3);
          return;
        end
        expPay.push_back({8'(k - 1), beats[start + k].data});
        sum += beats[start + k].data;
      end
      if (!beats[start + n + 1].last)              expectBad(3'd4);
      else if (beats[start + n + 1].data != sum)   expectBad(3'd5);
      else                                         expectGood(hdr[15:8]);
    end
  endtask

  // kind: 0 good, 1 bad checksum, 2 bad magic, 3 bad length, 4 early tlast,
  // 5 missing tlast, 6 tlast on header
  task automatic makePacket(input int kind, input int maxGap);
    int          start, n, k;
    logic [15:0] magic;
    logic [7:0]  src;
    logic [31:0] hdr, sum, w;
    start = beats.size();
    src   = 8'($urandom);
    magic = MAGIC;
    n     = $urandom_range(MAX_WORDS, 1);
    if (kind == 2) magic = MAGIC ^ 16'($urandom_range(16'hFFFF, 1));
    if (kind == 3) n = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, MAX_WORDS + 1);
    hdr = {magic, src, 8'(n)};
    case (kind)
      6: addBeat(hdr, 1'b1, $urandom_range(maxGap, 0));
      2: begin
        addBeat(hdr, 1'b0, $urandom_range(maxGap, 0));
        for (int j = 0; j < n; j++) addBeat($urandom, 1'b0, $urandom_range(maxGap, 0));
        addBeat($urandom, 1'b1, $urandom_range(maxGap, 0));
      end
      3: begin
        addBeat(hdr, 1'b0, $urandom_range(maxGap, 0));
        addBeat($urandom, 1'b0, $urandom_range(maxGap, 0));
        addBeat($urandom, 1'b1, $urandom_range(maxGap, 0));
      end
      4: begin
        k = $urandom_range(n, 1);
        addBeat(hdr, 1'b0, $urandom_range(maxGap, 0));
        for (int j = 1; j <= k; j++) addBeat($urandom, j == k, $urandom_range(maxGap, 0));
      end
      default: begin
        addBeat(hdr, 1'b0, $urandom_range(maxGap, 0));
        sum = hdr;
        for (int j = 0; j < n; j++) begin
          w = $urandom;
          sum += w;
          addBeat(w, 1'b0, $urandom_range(maxGap, 0));
        end
        if (kind == 1) sum ^= (32'd1 << $urandom_range(31, 0));
        addBeat(sum, kind != 5, $urandom_range(maxGap, 0));
        if (kind == 5) addBeat($urandom, 1'b1, $urandom_range(maxGap, 0));
      end
    endcase
    predict(start);
  endtask

  task automatic verifyState(input string tag);
    repeat (3) @(negedge auroraUserClk);
    checkOutput({tag, "/payCount"}, 40'(gotPay.size()), 40'(expPay.size()));
    for (int i = payChecked; i < expPay.size(); i++)
      if (i < gotPay.size()) checkOutput({tag, "/payWord"}, gotPay[i], expPay[i]);
    payChecked = expPay.size();
    checkOutput({tag, "/goodStrobes"}, 40'(gotGood), 40'(expGood));
    checkOutput({tag, "/badStrobes"}, 40'(gotBad), 40'(expBad));
    checkOutput({tag, "/good_count"}, 40'(good_count), 40'(expGoodCnt));
    checkOutput({tag, "/bad_count"}, 40'(bad_count), 40'(expBadCnt));
    checkOutput({tag, "/err_code"}, 40'(err_code), 40'(expErr));
    checkOutput({tag, "/src_id"}, 40'(src_id), 40'(expSrc));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/pay_tdata"}, 40'(pay_tdata), 40'd0);
    checkOutput({tag, "/pay_tvalid"}, 40'(pay_tvalid), 40'd0);
    checkOutput({tag, "/pay_index"}, 40'(pay_index), 40'd0);
    checkOutput({tag, "/pkt_good"}, 40'(pkt_good), 40'd0);
    checkOutput({tag, "/pkt_bad"}, 40'(pkt_bad), 40'd0);
    checkOutput({tag, "/err_code"}, 40'(err_code), 40'd0);
    checkOutput({tag, "/src_id"}, 40'(src_id), 40'd0);
    checkOutput({tag, "/good_count"}, 40'(good_count), 40'd0);
    checkOutput({tag, "/bad_count"}, 40'(bad_count), 40'd0);
  endtask

  initial begin
    int startIdx, goodBefore;

    repeat (3) @(negedge auroraUserClk);
    checkAllZero("reset");
    auroraResetN = 1'b1;
    @(negedge auroraUserClk);

    // Reference good packet from the test plan.
    startIdx = beats.size();
    addBeat(32'hA5C3_0703, 1'b0, 0);
    addBeat(32'h1, 1'b0, 0);
    addBeat(32'h2, 1'b0, 0);
    addBeat(32'h3, 1'b0, 0);
    addBeat(32'hA5C3_0709, 1'b1, 0);
    predict(startIdx);
    applyStimulus();
    verifyState("goodPkt");
    checkOutput("goodPkt/src_const", 40'(src_id), 40'h07);
    checkOutput("goodPkt/count_const", 40'(good_count), 40'd1);

    startIdx = beats.size();
    addBeat(32'hA5C3_0703, 1'b0, 0);
    addBeat(32'h1, 1'b0, 0);
    addBeat(32'h2, 1'b0, 1);
    addBeat(32'h3, 1'b0, 0);
    addBeat(32'hA5C3_070A, 1'b1, 0);
    predict(startIdx);
    applyStimulus();
    verifyState("badSum");
    checkOutput("badSum/err_const", 40'(err_code), 40'd5);

    startIdx = beats.size();
    addBeat(32'h1234_0102, 1'b0, 0);
    addBeat(32'hDEAD_0001, 1'b0, 0);
    addBeat(32'hDEAD_0002, 1'b0, 0);
    addBeat(32'hDEAD_0003, 1'b1, 0);
    predict(startIdx);
    applyStimulus();
    verifyState("badMagic");
    makePacket(0, 1);
    applyStimulus();
    verifyState("afterDrain");

    startIdx = beats.size();
    addBeat(32'hA5C3_0103, 1'b0, 0);
    addBeat(32'h1, 1'b0, 0);
    addBeat(32'h2, 1'b1, 0);
    predict(startIdx);
    applyStimulus();
    verifyState("earlyLast");

    startIdx = beats.size();
    addBeat(32'hA5C3_0128, 1'b0, 0);
    addBeat(32'h1, 1'b0, 0);
    addBeat(32'h2, 1'b1, 0);
    predict(startIdx);
    applyStimulus();
    verifyState("lenTooBig");
    checkOutput("lenTooBig/err_const", 40'(err_code), 40'd2);

    // Stall mid-payload: abort lands exactly on the TIMEOUT-th idle cycle.
    addBeat(32'hA5C3_0903, 1'b0, 0);
    addBeat(32'h11, 1'b0, 0);
    applyStimulus();
    expPay.push_back({8'd0, 32'h11});
    repeat (TIMEOUT - 1) @(negedge auroraUserClk);
    checkOutput("timeout/before", 40'(pkt_bad), 40'd0);
    @(negedge auroraUserClk);
    checkOutput("timeout/strobe", 40'(pkt_bad), 40'd1);
    checkOutput("timeout/err", 40'(err_code), 40'd6);
    expectBad(3'd6);
    verifyState("timeout");

    addBeat(32'h1234_0102, 1'b0, 0);
    applyStimulus();
    expectBad(3'd1);
    repeat (TIMEOUT + 20) @(negedge auroraUserClk);
    verifyState("drainTimeout");
    makePacket(0, 1);
    applyStimulus();
    verifyState("afterDrainTimeout");

    addBeat(32'hA5C3_0202, 1'b0, 0);
    addBeat(32'h5, 1'b0, 0);
    applyStimulus();
    expPay.push_back({8'd0, 32'h5});
    auroraResetN = 1'b0;
    repeat (2) @(negedge auroraUserClk);
    checkAllZero("midReset");
    auroraResetN = 1'b1;
    expGoodCnt = '0;
    expBadCnt  = '0;
    expErr     = '0;
    expSrc     = '0;
    verifyState("afterReset");
    makePacket(0, 1);
    applyStimulus();
    verifyState("goodAfterReset");

    goodBefore = expGood;
    makePacket(0, 0);
    makePacket(0, 0);
    applyStimulus();
    verifyState("backToBack");
    checkOutput("backToBack/pair", 40'(gotGood - goodBefore), 40'd2);

    force dut.r_goodCount = 16'hFFFE;
    @(negedge auroraUserClk);
    release dut.r_goodCount;
    expGoodCnt = 16'hFFFE;
    checkOutput("sat/preload", 40'(good_count), 40'hFFFE);
    makePacket(0, 1);
    applyStimulus();
    verifyState("satReach");
    makePacket(0, 1);
    applyStimulus();
    verifyState("satHold");

    for (int i = 0; i < 40; i++) begin
      makePacket($urandom_range(6, 0), 2);
      applyStimulus();
      verifyState("random");
    end

    checkOutput("neverBoth", 40'(gotBoth), 40'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cell_stream_rx_checker.md
Name: cell_stream_rx_checker

Overview:
- Consumes the cell-link AXI Stream RX output (CCW or CW, one instance per direction), delineates packets, and validates them.
- Forwards payload words downstream.
- Produces per-packet good/bad strobes, error codes and saturating counters.
- Sits directly downstream of the RX stream in both the simulation bench and the cell-controller fabric.

Parameters:
- MAGIC, 16'hA5C3, required value of header bits [31:16].
- MAX_WORDS, 32, largest legal payload length (1..255).
- TIMEOUT, 1024, idle cycles allowed mid-packet before abort (≥2).

Ports:
- auroraUserClk  in  1  stream clock; all logic on rising edge.
- auroraResetN  in  1  reset, synchronous, active-low.
- rx_tdata  in  32  RX stream data.
- rx_tlast  in  1  RX stream end-of-packet.
- rx_tvalid  in  1  RX stream valid; no tready, so every valid beat must be accepted.
- pay_tdata  out  32  forwarded payload word.
- pay_tvalid  out  1  payload word strobe.
- pay_index  out  8  0-based payload word index.
- pkt_good  out  1  one-cycle strobe, packet passed.
- pkt_bad  out  1  one-cycle strobe, packet failed.
- err_code  out  3  cause of last failure; held until the next pkt_bad.
- src_id  out  8  source ID of last good packet.
- good_count  out  16  saturating count of good packets.
- bad_count  out  16  saturating count of bad packets.

Behaviour:
- Packet format:
  - Header word: [31:16] MAGIC, [15:8] source ID, [7:0] N.
  - N payload words follow.
  - Final checksum word = 32-bit wrap-around sum of header and all payload words.
  - tlast is asserted only on the checksum word.
- Reset (auroraResetN=0 sampled on a clock edge):
  - All outputs 0, state IDLE, accumulator, index and timeout counter cleared.
  - Reset mid-packet discards the packet with no strobe.
- State IDLE, on a valid beat:
  - Header with bad magic → err 1.
  - N=0 or N>MAX_WORDS → err 2.
  - tlast on header → err 3, pkt_bad, stay IDLE.
  - Bad header without tlast → err 1/2, pkt_bad, go DRAIN.
  - Otherwise latch N and source ID, sum=header, idx=0, go PAYLOAD.
- State PAYLOAD, on a valid beat:
  - tlast set → err 3 (early tlast), pkt_bad, go IDLE.
  - Else forward word, sum+=word, idx++; idx reaching N → go CHECK.
- State CHECK, on a valid beat:
  - tlast=0 → err 4 (missing tlast), pkt_bad, go DRAIN.
  - tlast=1 and word≠sum → err 5, pkt_bad, go IDLE.
  - Else pkt_good, latch src_id, go IDLE.
- State DRAIN: discard beats until a beat with tlast, then go IDLE. No further strobes.
- Timeout:
  - In PAYLOAD/CHECK/DRAIN, the counter increments on each cycle with tvalid=0 and clears on any valid beat.
  - Reaching TIMEOUT → err 6, pkt_bad, go IDLE.
  - In DRAIN, timeout returns to IDLE silently: no second pkt_bad for the same packet.
- Latency:
  - pay_tvalid/pay_tdata/pay_index registered one cycle after the accepting beat.
  - pkt_good/pkt_bad asserted the cycle after the deciding beat; never both in one cycle.
- Counters: increment alongside the strobes; saturate at 16'hFFFF with no wrap.
- Payload words of a packet later found bad are still forwarded; consumers qualify with pkt_good.
- Back-to-back: a header immediately after a checksum beat (no gap) is accepted.

Test Plan:
- Good packet: header A5C3_0703, payload 1,2,3, checksum A5C3_0709, tlast on the checksum word → pay_tvalid 3 cycles with idx 0..2; pkt_good once; src_id=07; good_count=1.
- Checksum corrupted to A5C3_070A → pkt_bad, err_code=5, bad_count=1, good_count unchanged.
- Header 1234_0102 then 3 beats, tlast on the third → pkt_bad on header (err 1); DRAIN; next good packet accepted with pkt_good.
- N=3 with tlast on the second payload word → err 3, IDLE. N=40 (>MAX_WORDS) → err 2.
- Stall 1024 cycles after the first payload word → err 6 exactly at the count. Also pull auroraResetN low mid-packet → all outputs 0, no strobe.
- Preload good_count=FFFF (or send 65536 good packets via force) → stays FFFF. Back-to-back good packets with zero gap → two pkt_good strobes.
